hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Pipeline control sequencer for the 5-stage RV32I pipeline; sits beside the main control decoder.
- Generates per-stage write enables, flushes and bubbles: load-use stalls, taken-branch flushes, and whole-pipeline freezes while data memory is not ready.
- Watches data-memory wait time, raises a sticky timeout error, and keeps a saturating stall-cycle performance counter.

Parameters:
- MAX_WAIT, 15, maximum consecutive not-ready cycles tolerated before timeout (1..2^WAIT_W-1)
- WAIT_W, 4, width of the wait counter
- CNT_W, 16, width of stall_cycles

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_opcode  in  7  opcode of the instruction in ID
- id_rs1  in  5  rs1 field in ID
- id_rs2  in  5  rs2 field in ID
- ex_memread  in  1  memread control bit of the instruction in EX
- ex_rd  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_req  in  1  instruction in MEM has memread or memwrite set
- dmem_ready  in  1  data memory completes the access this cycle
- err_clear  in  1  clears the timeout error state
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID cleared to NOP
- idex_write  out  1  ID/EX register enable
- idex_flush  out  1  ID/EX control bits zeroed (bubble)
- exmem_write  out  1  EX/MEM register enable
- memwb_bubble  out  1  MEM/WB loads zero control bits
- mem_timeout  out  1  sticky timeout flag
- stall_cycles  out  CNT_W  count of cycles with pc_write=0

Behaviour:
- Register use in ID:
  - rs1 is used for opcodes 0110011, 0010011, 0000011, 0100011, 1100011.
  - rs2 is used only for 0110011, 0100011, 1100011.
  - No other opcode uses rs1 or rs2.
- load_use = ex_memread & (ex_rd != 0) & ((rs1 used & ex_rd == id_rs1) | (rs2 used & ex_rd == id_rs2)).
- FSM states: RUN, MEM_WAIT, ERROR. Registered bit `live` is 0 in reset and goes to 1 on the first clock edge after rst_n deasserts.
- Reset (rst_n=0, asynchronous):
  - State goes to RUN; wait_cnt, stall_cycles, mem_timeout and live are cleared.
  - While live=0, all write, flush and bubble outputs are 0.
- Outputs are combinational from state and inputs (zero latency). Evaluation in RUN uses this priority:
  1. mem_req & !dmem_ready:
     - Freeze: pc_write, ifid_write, idex_write and exmem_write = 0; memwb_bubble=1; flushes are 0.
     - Next state MEM_WAIT, wait_cnt=1.
  2. ex_branch_taken:
     - All writes = 1; ifid_flush=1, idex_flush=1.
     - load_use is ignored because the ID instruction is squashed.
  3. load_use:
     - pc_write=0, ifid_write=0, idex_flush=1; idex_write and exmem_write = 1.
     - Lasts one cycle, because the load moves to MEM.
  4. Otherwise all writes = 1 and flushes/bubble = 0.
- MEM_WAIT:
  - dmem_ready=0:
    - Freeze as in RUN case 1; wait_cnt increments.
    - If wait_cnt == MAX_WAIT: next state ERROR, mem_timeout set to 1.
  - dmem_ready=1 (release cycle):
    - Outputs follow RUN priorities 2–4. EX and ID contents were held, so a pending taken branch or load-use takes effect here.
    - Next state RUN, wait_cnt=0.
- ERROR:
  - All writes = 0, memwb_bubble=1, mem_timeout=1.
  - err_clear=1: next state RUN, mem_timeout=0, wait_cnt=0. Outputs stay frozen during the err_clear cycle.
- stall_cycles:
  - Increments on every clock with live=1 and pc_write=0; saturates at all-ones (no wrap).
  - Count sources: load-use, MEM_WAIT and ERROR cycles.
- Simultaneous events:
  - mem_req & !dmem_ready together with a branch: freeze wins; the flush is applied in the release cycle.
  - err_clear outside ERROR is ignored.

Test Plan:
1. Reset then idle: rst_n low 3 cycles, then high.
   - Outputs all 0 until the first edge after release, then pc/ifid/idex/exmem_write=1 and flushes=0.
   - stall_cycles=0.
2. Load-use on rs1: ex_memread=1, ex_rd=5, id_opcode=0110011, id_rs1=5.
   - One cycle pc_write=0, ifid_write=0, idex_flush=1; stall_cycles=1.
   - Repeat with ex_rd=0 or opcode 0010011 and rs2-only match: no stall.
3. Taken branch plus load_use in the same cycle:
   - ifid_flush=1, idex_flush=1, pc_write=1; no stall; stall_cycles unchanged.
4. Memory wait: mem_req=1, dmem_ready=0 for 3 cycles, with ex_branch_taken=1 held, then dmem_ready=1.
   - 3 frozen cycles with memwb_bubble=1.
   - Release cycle: all writes=1 and ifid_flush=idex_flush=1.
   - stall_cycles=3.
5. Timeout: dmem_ready=0 for MAX_WAIT=15 cycles.
   - ERROR is entered, mem_timeout=1, and outputs stay frozen.
   - err_clear pulse returns to RUN next cycle with mem_timeout=0.
6. Saturation and async reset: CNT_W=4 with 20 stall cycles gives stall_cycles=15.
   - rst_n asserted mid-MEM_WAIT clears state, counter and outputs immediately.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Pipeline control sequencer for the 5-stage RV32I pipeline.
//
// Produces per-stage write enables, flushes and bubbles:
//   - load-use stall (one cycle, ID/EX bubble, PC and IF/ID held)
//   - taken-branch flush of IF/ID and ID/EX
//   - whole-pipeline freeze while data memory is not ready
// It also raises a sticky timeout when data memory stays not-ready too long,
// and counts stalled cycles (pc_write=0) in a saturating counter.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   id_opcode/rs1/rs2   instruction fields in ID
//   ex_memread, ex_rd   load indication and destination in EX
//   ex_branch_taken     branch in EX resolved taken
//   mem_req, dmem_ready MEM-stage access request and completion
//   err_clear           leaves the timeout error state
//   pc_write .. memwb_bubble  pipeline control outputs (combinational)
//   mem_timeout         sticky timeout flag
//   stall_cycles        saturating count of cycles with pc_write=0
module hazard_sequencer #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic             err_clear,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;
  logic               live_q;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  // Register usage decode for the instruction in ID.
  logic rs1_used, rs2_used, load_use;

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (id_opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      7'b0010011, 7'b0000011: rs1_used = 1'b1;
      default: ;
    endcase
  end

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((rs1_used && (ex_rd == id_rs1)) || (rs2_used && (ex_rd == id_rs2)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      live_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      live_q      <= 1'b1;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic. Nothing advances until the pipeline is live.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    if (live_q) begin
      unique case (state_q)
        StRun: begin
          if (mem_req && !dmem_ready) begin
            state_d    = StMemWait;
            wait_cnt_d = WAIT_W'(1);
          end
        end
        StMemWait: begin
          if (!dmem_ready) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            // wait_cnt_d equals the number of not-ready cycles seen so far.
            if (wait_cnt_d >= MaxWait) begin
              state_d   = StError;
              timeout_d = 1'b1;
            end
          end else begin
            state_d    = StRun;
            wait_cnt_d = '0;
          end
        end
        StError: begin
          if (err_clear) begin
            state_d    = StRun;
            timeout_d  = 1'b0;
            wait_cnt_d = '0;
          end
        end
        default: begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end
      endcase
    end
  end

  // Output logic: zero latency from state and inputs.
  logic freeze, advance;

  always_comb begin
    freeze       = 1'b0;
    advance      = 1'b0;
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_write   = 1'b0;
    idex_flush   = 1'b0;
    exmem_write  = 1'b0;
    memwb_bubble = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_req && !dmem_ready) freeze = 1'b1;
        else                        advance = 1'b1;
      end
      // Release cycle: EX/ID were held, so branch/load-use apply now.
      StMemWait: begin
        if (!dmem_ready) freeze = 1'b1;
        else             advance = 1'b1;
      end
      StError: freeze = 1'b1;
      default: freeze = 1'b1;
    endcase

    if (live_q) begin
      if (freeze) begin
        memwb_bubble = 1'b1;
      end else if (advance) begin
        if (ex_branch_taken) begin
          // ID instruction is squashed, so load-use does not matter.
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_write  = 1'b1;
          exmem_write = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
        end else if (load_use) begin
          idex_write  = 1'b1;
          exmem_write = 1'b1;
          idex_flush  = 1'b1;
        end else begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_write  = 1'b1;
          exmem_write = 1'b1;
        end
      end
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (live_q && !pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer. A second instance with a
// 4-bit stall counter shares all inputs to exercise counter saturation.
module tb_hazard_sequencer;

  logic        clk;
  logic        rst_n;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_memread, ex_branch_taken, mem_req, dmem_ready, err_clear;

  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic        exmem_write, memwb_bubble, mem_timeout;
  logic [15:0] stall_cycles;

  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_write, s_idex_flush;
  logic        s_exmem_write, s_memwb_bubble, s_mem_timeout;
  logic [3:0]  s_stall_cycles;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble}
  logic [6:0] ctl;
  assign ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write,
                memwb_bubble};

  localparam logic [6:0] CtlOff    = 7'b0000000;
  localparam logic [6:0] CtlNorm   = 7'b1101010;
  localparam logic [6:0] CtlFreeze = 7'b0000001;
  localparam logic [6:0] CtlBranch = 7'b1111110;
  localparam logic [6:0] CtlLdUse  = 7'b0001110;

  int n_checks = 0;
  int n_errors = 0;

  hazard_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_opcode       (id_opcode),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .dmem_ready      (dmem_ready),
    .err_clear       (err_clear),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_write      (idex_write),
    .idex_flush      (idex_flush),
    .exmem_write     (exmem_write),
    .memwb_bubble    (memwb_bubble),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles)
  );

  hazard_sequencer #(.CNT_W(4)) dut_sat (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_opcode       (id_opcode),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .dmem_ready      (dmem_ready),
    .err_clear       (err_clear),
    .pc_write        (s_pc_write),
    .ifid_write      (s_ifid_write),
    .ifid_flush      (s_ifid_flush),
    .idex_write      (s_idex_write),
    .idex_flush      (s_idex_flush),
    .exmem_write     (s_exmem_write),
    .memwb_bubble    (s_memwb_bubble),
    .mem_timeout     (s_mem_timeout),
    .stall_cycles    (s_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_opcode       = 7'b0010011;
    id_rs1          = 5'd0;
    id_rs2          = 5'd0;
    ex_memread      = 1'b0;
    ex_rd           = 5'd0;
    ex_branch_taken = 1'b0;
    mem_req         = 1'b0;
    dmem_ready      = 1'b1;
    err_clear       = 1'b0;
  endtask

  // Inputs change just after a falling edge; checks follow 1 time unit later.
  task automatic tick();
    @(negedge clk);
  endtask

  // Returns at the falling edge where the DUT has just become live.
  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // 1. Reset then idle
    #1;
    check("rst_ctl", 32'(ctl), 32'(CtlOff));
    check("rst_stall", 32'(stall_cycles), 0);
    check("rst_timeout", 32'(mem_timeout), 0);
    repeat (3) @(posedge clk);
    tick();
    rst_n = 1'b1;
    #1 check("pre_live_ctl", 32'(ctl), 32'(CtlOff));
    tick();
    #1 check("idle_ctl", 32'(ctl), 32'(CtlNorm));
    check("idle_stall", 32'(stall_cycles), 0);

    // 2. Load-use detection
    tick();
    ex_memread = 1'b1; ex_rd = 5'd5; id_opcode = 7'b0110011; id_rs1 = 5'd5; id_rs2 = 5'd0;
    #1 check("lu_rs1", 32'(ctl), 32'(CtlLdUse));
    tick();
    ex_memread = 1'b0;
    #1 check("lu_done", 32'(ctl), 32'(CtlNorm));
    check("lu_stall1", 32'(stall_cycles), 1);
    tick();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    #1 check("lu_x0", 32'(ctl), 32'(CtlNorm));
    tick();
    ex_rd = 5'd5; id_opcode = 7'b0010011; id_rs1 = 5'd3; id_rs2 = 5'd5;
    #1 check("lu_rs2_unused", 32'(ctl), 32'(CtlNorm));
    tick();
    id_opcode = 7'b1101111; id_rs1 = 5'd5;
    #1 check("lu_jal", 32'(ctl), 32'(CtlNorm));
    tick();
    id_opcode = 7'b0100011; id_rs1 = 5'd3; id_rs2 = 5'd5;
    #1 check("lu_store_rs2", 32'(ctl), 32'(CtlLdUse));
    tick();
    ex_memread = 1'b0;
    #1 check("lu_store_done", 32'(ctl), 32'(CtlNorm));
    check("lu_stall2", 32'(stall_cycles), 2);

    // 3. Taken branch overrides load-use
    tick();
    ex_memread = 1'b1; ex_rd = 5'd5; id_opcode = 7'b0110011; id_rs1 = 5'd5;
    ex_branch_taken = 1'b1;
    #1 check("br_lu", 32'(ctl), 32'(CtlBranch));
    tick();
    idle_inputs();
    #1 check("br_after", 32'(ctl), 32'(CtlNorm));
    check("br_stall", 32'(stall_cycles), 2);

    // 4. Memory wait with pending branch
    do_reset();
    tick();
    mem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    #1 check("mw_freeze0", 32'(ctl), 32'(CtlFreeze));
    for (int i = 1; i < 3; i++) begin
      tick();
      #1 check("mw_freeze", 32'(ctl), 32'(CtlFreeze));
    end
    tick();
    dmem_ready = 1'b1;
    #1 check("mw_release", 32'(ctl), 32'(CtlBranch));
    check("mw_no_timeout", 32'(mem_timeout), 0);
    tick();
    idle_inputs();
    #1 check("mw_after", 32'(ctl), 32'(CtlNorm));
    check("mw_stall", 32'(stall_cycles), 3);

    // 5. Timeout after MAX_WAIT not-ready cycles
    do_reset();
    tick();
    mem_req = 1'b1; dmem_ready = 1'b0;
    #1 check("to_freeze0", 32'(ctl), 32'(CtlFreeze));
    for (int i = 1; i < 15; i++) begin
      tick();
      #1 check("to_freeze", 32'(ctl), 32'(CtlFreeze));
      check("to_not_yet", 32'(mem_timeout), 0);
    end
    tick();
    #1 check("to_set", 32'(mem_timeout), 1);
    check("to_err_freeze", 32'(ctl), 32'(CtlFreeze));
    tick();
    mem_req = 1'b0; dmem_ready = 1'b1;
    #1 check("to_err_ready", 32'(ctl), 32'(CtlFreeze));
    tick();
    err_clear = 1'b1;
    #1 check("to_clear_cycle", 32'(ctl), 32'(CtlFreeze));
    check("to_clear_flag", 32'(mem_timeout), 1);
    tick();
    err_clear = 1'b0;
    #1 check("to_run", 32'(ctl), 32'(CtlNorm));
    check("to_cleared", 32'(mem_timeout), 0);
    check("to_stall", 32'(stall_cycles), 18);
    tick();
    err_clear = 1'b1;
    #1 check("clr_in_run", 32'(ctl), 32'(CtlNorm));
    tick();
    err_clear = 1'b0;
    #1 check("clr_in_run_stall", 32'(stall_cycles), 18);

    // 6. Saturation and asynchronous reset in MEM_WAIT
    do_reset();
    tick();
    mem_req = 1'b1; dmem_ready = 1'b0;
    repeat (19) tick();
    tick();
    #1 check("sat_wide", 32'(stall_cycles), 20);
    check("sat_narrow", 32'(s_stall_cycles), 15);
    check("sat_timeout", 32'(mem_timeout), 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    tick();
    #1 check("mid_wait_ctl", 32'(ctl), 32'(CtlFreeze));
    check("mid_wait_timeout", 32'(mem_timeout), 0);
    check("mid_wait_stall", 32'(stall_cycles), 22);
    #2 rst_n = 1'b0;
    #1 check("async_ctl", 32'(ctl), 32'(CtlOff));
    check("async_stall", 32'(stall_cycles), 0);
    check("async_stall_sat", 32'(s_stall_cycles), 0);
    tick();
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    #1 check("post_reset", 32'(ctl), 32'(CtlNorm));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
